// File: rtl/uart_bus_master_pkg.sv
// Shared constants and state encodings for the UART debug bus master.
package uart_bus_master_pkg;

    // Command opcodes received from the host
    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;

    // Single-byte replies
    localparam logic [7:0] RPL_ACK  = 8'h06;
    localparam logic [7:0] RPL_NAK  = 8'h15;

    // Frame-level controller states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_GET_DATA,
        ST_BUS_WR,
        ST_BUS_RD,
        ST_SEND
    } state_e;

    // Serial receiver states
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_bus_master_if.sv
// Memory-mapped peripheral bus: single-word read/write strobes with shared address.
interface uart_bus_master_if;
    logic [31:0] Addr;
    logic [31:0] WData;
    logic [31:0] RData;
    logic        Read;
    logic        Write;

    modport master (
        output Addr,
        output WData,
        output Read,
        output Write,
        input  RData
    );

    modport slave (
        input  Addr,
        input  WData,
        input  Read,
        input  Write,
        output RData
    );
endinterface

// File: rtl/uart_bus_master_bit_engine.sv
// 8N1 serial deserialiser and serialiser sharing one bit period (DIV clocks).
module uart_bus_master_bit_engine
    import uart_bus_master_pkg::*;
#(
    parameter int DIV = 5208
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic       tx_o,
    input  logic       tx_start_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_busy_o,
    output logic       rx_valid_o,
    output logic       rx_err_o,
    output logic [7:0] rx_data_o
);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

    logic            rx_s1_q, rx_s2_q, rx_prev_q;
    rx_state_e       rx_st_q, rx_st_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_sh_q, rx_sh_d;
    logic            rx_valid_q, rx_valid_d;
    logic            rx_err_q, rx_err_d;

    logic            tx_q, tx_d;
    logic            tx_busy_q, tx_busy_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [3:0]      tx_bit_q, tx_bit_d;
    logic [7:0]      tx_sh_q, tx_sh_d;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= rx_i;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    // Receiver next state: mid-bit sampling, start bit re-checked at DIV/2
    always_comb begin
        rx_st_d    = rx_st_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;
        case (rx_st_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_st_d  = RX_START;
                    rx_cnt_d = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_M1) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    // A start bit that has gone high again was only a glitch
                    rx_st_d  = rx_s2_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == FULL_M1) begin
                    rx_cnt_d = '0;
                    rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_st_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == FULL_M1) begin
                    rx_cnt_d   = '0;
                    rx_st_d    = RX_IDLE;
                    rx_valid_d = rx_s2_q;
                    rx_err_d   = !rx_s2_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            default: rx_st_d = RX_IDLE;
        endcase
    end

    // Receiver state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_st_q    <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            rx_st_q    <= rx_st_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_valid_q <= rx_valid_d;
            rx_err_q   <= rx_err_d;
        end
    end

    // Transmitter next state: bit 0 is start, 1..8 data LSB first, 9 stop
    always_comb begin
        tx_d      = tx_q;
        tx_busy_d = tx_busy_q;
        tx_cnt_d  = tx_cnt_q;
        tx_bit_d  = tx_bit_q;
        tx_sh_d   = tx_sh_q;
        if (!tx_busy_q) begin
            if (tx_start_i) begin
                tx_busy_d = 1'b1;
                tx_d      = 1'b0;
                tx_sh_d   = tx_data_i;
                tx_cnt_d  = '0;
                tx_bit_d  = '0;
            end
        end else if (tx_cnt_q == FULL_M1) begin
            tx_cnt_d = '0;
            if (tx_bit_q == 4'd9) begin
                tx_busy_d = 1'b0;
                tx_d      = 1'b1;
            end else begin
                tx_bit_d = tx_bit_q + 4'd1;
                if (tx_bit_q == 4'd8) begin
                    tx_d = 1'b1;
                end else begin
                    tx_d    = tx_sh_q[0];
                    tx_sh_d = {1'b0, tx_sh_q[7:1]};
                end
            end
        end else begin
            tx_cnt_d = tx_cnt_q + CW'(1);
        end
    end

    // Transmitter state register; line idles high out of reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_q      <= 1'b1;
            tx_busy_q <= 1'b0;
            tx_cnt_q  <= '0;
            tx_bit_q  <= '0;
            tx_sh_q   <= '0;
        end else begin
            tx_q      <= tx_d;
            tx_busy_q <= tx_busy_d;
            tx_cnt_q  <= tx_cnt_d;
            tx_bit_q  <= tx_bit_d;
            tx_sh_q   <= tx_sh_d;
        end
    end

    assign tx_o       = tx_q;
    assign tx_busy_o  = tx_busy_q;
    assign rx_valid_o = rx_valid_q;
    assign rx_err_o   = rx_err_q;
    assign rx_data_o  = rx_sh_q;

endmodule

// File: rtl/uart_bus_master.sv
// Serial debug initiator: decodes 'W'/'R' command frames from the host, runs one
// bus cycle and returns ACK or the read word; unknown opcodes get NAK.
module uart_bus_master
    import uart_bus_master_pkg::*;
#(
    parameter int DIV     = 5208,
    parameter int TIMEOUT = 2500000
) (
    input  logic               C,
    input  logic               R,
    input  logic               Rx,
    output logic               Tx,
    output logic               Busy,
    uart_bus_master_if.master  bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_e        state_q, state_d;
    logic [1:0]    bcnt_q, bcnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          is_wr_q, is_wr_d;
    logic [31:0]   ash_q, ash_d;
    logic [31:0]   dsh_q, dsh_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   reply_q, reply_d;
    logic [2:0]    rlen_q, rlen_d;

    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_busy;
    logic          rx_valid;
    logic          rx_err;
    logic [7:0]    rx_data;

    uart_bus_master_bit_engine #(.DIV(DIV)) u_bits (
        .clk_i      (C),
        .rst_ni     (R),
        .rx_i       (Rx),
        .tx_o       (Tx),
        .tx_start_i (tx_start),
        .tx_data_i  (tx_data),
        .tx_busy_o  (tx_busy),
        .rx_valid_o (rx_valid),
        .rx_err_o   (rx_err),
        .rx_data_o  (rx_data)
    );

    // Frame decoder: collects fields MSB first, strobes the bus, queues the reply
    always_comb begin
        state_d  = state_q;
        bcnt_d   = bcnt_q;
        tmo_d    = tmo_q;
        is_wr_d  = is_wr_q;
        ash_d    = ash_q;
        dsh_d    = dsh_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        reply_d  = reply_q;
        rlen_d   = rlen_q;
        tx_start = 1'b0;
        tx_data  = reply_q[31:24];
        case (state_q)
            ST_IDLE: begin
                tmo_d  = '0;
                bcnt_d = '0;
                if (rx_valid) begin
                    if (rx_data == OP_WRITE || rx_data == OP_READ) begin
                        is_wr_d = (rx_data == OP_WRITE);
                        state_d = ST_GET_ADDR;
                    end else begin
                        reply_d = {RPL_NAK, 24'h0};
                        rlen_d  = 3'd1;
                        state_d = ST_SEND;
                    end
                end
            end
            ST_GET_ADDR: begin
                if (rx_err) begin
                    state_d = ST_IDLE;
                end else if (rx_valid) begin
                    ash_d  = {ash_q[23:0], rx_data};
                    tmo_d  = '0;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        if (is_wr_q) begin
                            state_d = ST_GET_DATA;
                        end else begin
                            // Address is presented on the bus only when the strobe is due
                            addr_d  = {ash_q[23:0], rx_data};
                            state_d = ST_BUS_RD;
                        end
                    end
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_GET_DATA: begin
                if (rx_err) begin
                    state_d = ST_IDLE;
                end else if (rx_valid) begin
                    dsh_d  = {dsh_q[23:0], rx_data};
                    tmo_d  = '0;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        addr_d  = ash_q;
                        wdata_d = {dsh_q[23:0], rx_data};
                        state_d = ST_BUS_WR;
                    end
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_BUS_WR: begin
                reply_d = {RPL_ACK, 24'h0};
                rlen_d  = 3'd1;
                state_d = ST_SEND;
            end
            ST_BUS_RD: begin
                reply_d = bus.RData;
                rlen_d  = 3'd4;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (!tx_busy) begin
                    if (rlen_q == 3'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        tx_start = 1'b1;
                        reply_d  = {reply_q[23:0], 8'h00};
                        rlen_d   = rlen_q - 3'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Frame decoder state and datapath registers
    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            state_q <= ST_IDLE;
            bcnt_q  <= '0;
            tmo_q   <= '0;
            is_wr_q <= 1'b0;
            ash_q   <= '0;
            dsh_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            reply_q <= '0;
            rlen_q  <= '0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            tmo_q   <= tmo_d;
            is_wr_q <= is_wr_d;
            ash_q   <= ash_d;
            dsh_q   <= dsh_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            reply_q <= reply_d;
            rlen_q  <= rlen_d;
        end
    end

    assign bus.Addr  = addr_q;
    assign bus.WData = wdata_q;
    assign bus.Read  = (state_q == ST_BUS_RD);
    assign bus.Write = (state_q == ST_BUS_WR);
    assign Busy      = (state_q != ST_IDLE) || tx_busy;

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master with DIV=16, TIMEOUT=2000.
module tb_uart_bus_master;
    localparam int DIV     = 16;
    localparam int TIMEOUT = 2000;

    logic C = 1'b0;
    logic R;
    logic Rx;
    logic Tx;
    logic Busy;

    uart_bus_master_if bus_if();

    uart_bus_master #(.DIV(DIV), .TIMEOUT(TIMEOUT)) dut (
        .C    (C),
        .R    (R),
        .Rx   (Rx),
        .Tx   (Tx),
        .Busy (Busy),
        .bus  (bus_if)
    );

    always #5 C = ~C;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          nbytes;
        logic [71:0] frame;      // first byte in [71:64]
        logic [31:0] rdata;
        int          exp_wr;
        int          exp_rd;
        logic [31:0] exp_addr;   // Addr after the frame (strobe value or held value)
        logic [31:0] exp_wdata;
        logic [31:0] exp_reply;  // first reply byte in [31:24]
        int          exp_rlen;
    } vec_t;

    vec_t vecs[8];

    // bus and serial monitors
    int          wr_cnt = 0, rd_cnt = 0, both_cnt = 0;
    int          wr_run = 0, rd_run = 0, wr_max = 0, rd_max = 0;
    logic [31:0] wr_addr = '0, wr_data = '0, rd_addr = '0;
    logic [7:0]  rxq[$];
    int          tx_falls = 0;
    int          tx_stop_bad = 0;
    int          rst_epoch = 0;

    always @(negedge C) begin
        if (bus_if.Write) begin
            wr_cnt++;
            wr_addr = bus_if.Addr;
            wr_data = bus_if.WData;
            wr_run++;
        end else begin
            wr_run = 0;
        end
        if (bus_if.Read) begin
            rd_cnt++;
            rd_addr = bus_if.Addr;
            rd_run++;
        end else begin
            rd_run = 0;
        end
        if (wr_run > wr_max) wr_max = wr_run;
        if (rd_run > rd_max) rd_max = rd_run;
        if (bus_if.Read && bus_if.Write) both_cnt++;
    end

    // Tx decoder: bytes interrupted by reset are discarded
    initial begin
        logic       tx_prev;
        logic [7:0] b;
        int         ep;
        tx_prev = 1'b1;
        forever begin
            @(negedge C);
            if (tx_prev && !Tx) begin
                tx_falls++;
                ep = rst_epoch;
                repeat (DIV / 2) @(negedge C);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge C);
                    b[i] = Tx;
                end
                repeat (DIV) @(negedge C);
                if (ep == rst_epoch) begin
                    if (!Tx) tx_stop_bad++;
                    rxq.push_back(b);
                end
            end
            tx_prev = Tx;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge C);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        Rx = 1'b0;
        wait_cyc(DIV);
        for (int i = 0; i < 8; i++) begin
            Rx = b[i];
            wait_cyc(DIV);
        end
        Rx = stop;
        wait_cyc(DIV);
        Rx = 1'b1;
        if (!stop) wait_cyc(2 * DIV);
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int k;
        k = 0;
        while (rxq.size() < n && k < budget) begin
            @(negedge C);
            k++;
        end
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (Busy && k < budget) begin
            @(negedge C);
            k++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int w0, r0;
        w0 = wr_cnt;
        r0 = rd_cnt;
        rxq.delete();
        bus_if.RData = v.rdata;
        for (int i = 0; i < v.nbytes; i++) send_byte(v.frame[71 - 8 * i -: 8], 1'b1);
        wait_bytes(v.exp_rlen, 3000);
        chk({tag, "_reply_len"}, rxq.size(), v.exp_rlen);
        for (int i = 0; i < v.exp_rlen; i++) begin
            chk({tag, "_reply_byte"}, (i < rxq.size()) ? {24'h0, rxq[i]} : 32'hFFFF_FFFF,
                {24'h0, v.exp_reply[31 - 8 * i -: 8]});
        end
        wait_idle(200);
        chk({tag, "_busy_end"}, {31'h0, Busy}, 32'h0);
        chk({tag, "_write_pulses"}, wr_cnt - w0, v.exp_wr);
        chk({tag, "_read_pulses"}, rd_cnt - r0, v.exp_rd);
        if (v.exp_wr == 1) begin
            chk({tag, "_wr_addr"}, wr_addr, v.exp_addr);
            chk({tag, "_wr_data"}, wr_data, v.exp_wdata);
        end
        if (v.exp_rd == 1) chk({tag, "_rd_addr"}, rd_addr, v.exp_addr);
        chk({tag, "_addr_hold"}, bus_if.Addr, v.exp_addr);
        chk({tag, "_wdata_hold"}, bus_if.WData, v.exp_wdata);
    endtask

    initial begin
        int w0, r0, f0;

        vecs[0] = '{9, {8'h57, 32'h4000_000C, 32'h0000_00A5}, 32'h0, 1, 0,
                    32'h4000_000C, 32'h0000_00A5, 32'h0600_0000, 1};
        vecs[1] = '{5, {8'h52, 32'h4000_0010, 32'h0}, 32'h0000_005A, 0, 1,
                    32'h4000_0010, 32'h0000_00A5, 32'h0000_005A, 4};
        vecs[2] = '{1, {8'h33, 64'h0}, 32'h0, 0, 0,
                    32'h4000_0010, 32'h0000_00A5, 32'h1500_0000, 1};
        vecs[3] = '{9, {8'h57, 32'h4000_0004, 32'hDEAD_BEEF}, 32'h0, 1, 0,
                    32'h4000_0004, 32'hDEAD_BEEF, 32'h0600_0000, 1};
        vecs[4] = '{5, {8'h52, 32'h4000_0004, 32'h0}, 32'h1234_5678, 0, 1,
                    32'h4000_0004, 32'hDEAD_BEEF, 32'h1234_5678, 4};
        vecs[5] = '{5, {8'h52, 32'hFFFF_FFFC, 32'h0}, 32'h8000_0001, 0, 1,
                    32'hFFFF_FFFC, 32'hDEAD_BEEF, 32'h8000_0001, 4};
        vecs[6] = '{9, {8'h57, 32'h4000_0008, 32'h0000_0003}, 32'h0, 1, 0,
                    32'h4000_0008, 32'h0000_0003, 32'h0600_0000, 1};
        vecs[7] = '{9, {8'h57, 32'h4000_0014, 32'h0000_FFFF}, 32'h0, 1, 0,
                    32'h4000_0014, 32'h0000_FFFF, 32'h0600_0000, 1};

        R = 1'b0;
        Rx = 1'b1;
        bus_if.RData = '0;
        wait_cyc(5);
        chk("rst_tx", {31'h0, Tx}, 32'h1);
        chk("rst_addr", bus_if.Addr, 32'h0);
        chk("rst_wdata", bus_if.WData, 32'h0);
        chk("rst_read", {31'h0, bus_if.Read}, 32'h0);
        chk("rst_write", {31'h0, bus_if.Write}, 32'h0);
        chk("rst_busy", {31'h0, Busy}, 32'h0);
        R = 1'b1;
        wait_cyc(4 * DIV);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // inter-byte timeout: frame abandoned after TIMEOUT idle clocks, silently
        w0 = wr_cnt; r0 = rd_cnt; f0 = tx_falls;
        send_byte(8'h57, 1'b1);
        send_byte(8'h40, 1'b1);
        wait_cyc(1000);
        chk("tmo_busy_mid", {31'h0, Busy}, 32'h1);
        wait_cyc(1100);
        chk("tmo_busy_after", {31'h0, Busy}, 32'h0);
        chk("tmo_strobes", (wr_cnt - w0) + (rd_cnt - r0), 0);
        chk("tmo_tx_activity", tx_falls - f0, 0);

        // framing error on the third byte aborts the frame
        w0 = wr_cnt; r0 = rd_cnt; f0 = tx_falls;
        send_byte(8'h52, 1'b1);
        send_byte(8'h40, 1'b1);
        send_byte(8'h00, 1'b0);
        chk("ferr_busy", {31'h0, Busy}, 32'h0);
        wait_cyc(4 * DIV);
        chk("ferr_strobes", (wr_cnt - w0) + (rd_cnt - r0), 0);
        chk("ferr_tx_activity", tx_falls - f0, 0);
        run_vec(vecs[6], "post_ferr");

        // low pulse shorter than the start-bit re-sample point is not a byte
        f0 = tx_falls;
        Rx = 1'b0;
        wait_cyc(DIV / 4);
        Rx = 1'b1;
        wait_cyc(3);
        chk("glitch_busy_early", {31'h0, Busy}, 32'h0);
        wait_cyc(14 * DIV);
        chk("glitch_busy", {31'h0, Busy}, 32'h0);
        chk("glitch_tx_activity", tx_falls - f0, 0);

        // reset while the third reply byte (0x00) of a read is on the line
        rxq.delete();
        bus_if.RData = 32'hCAFE_00F0;
        send_byte(8'h52, 1'b1);
        send_byte(8'h40, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h18, 1'b1);
        wait_bytes(2, 3000);
        chk("rstmid_len", rxq.size(), 2);
        chk("rstmid_b0", (rxq.size() > 0) ? {24'h0, rxq[0]} : 32'hFFFF_FFFF, 32'hCA);
        chk("rstmid_b1", (rxq.size() > 1) ? {24'h0, rxq[1]} : 32'hFFFF_FFFF, 32'hFE);
        wait_cyc(3 * DIV);
        chk("rstmid_tx_low", {31'h0, Tx}, 32'h0);
        R = 1'b0;
        rst_epoch++;
        rxq.delete();
        #1;
        chk("rstmid_tx", {31'h0, Tx}, 32'h1);
        chk("rstmid_busy", {31'h0, Busy}, 32'h0);
        chk("rstmid_addr", bus_if.Addr, 32'h0);
        chk("rstmid_read", {31'h0, bus_if.Read}, 32'h0);
        wait_cyc(3);
        R = 1'b1;
        wait_cyc(12 * DIV);
        rxq.delete();
        run_vec(vecs[7], "post_rst");

        chk("rw_exclusive", both_cnt, 0);
        chk("write_width", wr_max, 1);
        chk("read_width", rd_max, 1);
        chk("tx_stop_bits", tx_stop_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
